aes_serial_slave: RTL and testbench
===================================

AES_SERIAL_SLAVE -- requirements
Module: aes_serial_slave

Interface
REQ-001 Parameter NK, default 4, key length in 32-bit words; legal values 4/6/8; key bits KB = 32*NK.
REQ-002 clk  in  1  single clock; all state changes on posedge.
REQ-003 rst  in  1  reset, asynchronous, active-low.
REQ-004 cs  in  1  host chip select; high = host shifting in; low = host listening.
REQ-005 miso  in  1  serial data from host, sampled on posedge clk.
REQ-006 mosi  out  1  serial result to host, registered.
REQ-007 finished  out  1  one-cycle pulse after last result bit.
REQ-008 core_start  out  1  one-cycle pulse requesting one AES operation.
REQ-009 core_data  out  128  block to core; stable from core_start until core_done.
REQ-010 core_key  out  KB  key to core; stable from core_start until core_done.
REQ-011 core_done  in  1  core completion pulse; core_result valid in the same cycle.
REQ-012 core_result  in  128  processed block from core.
REQ-013 busy  out  1  high in every state except IDLE.
REQ-014 err  out  1  sticky protocol-error flag; present only with AES_SLV_ERR_EN.

Function
REQ-015 States SHALL be IDLE, LOAD, WAIT, HOLD, SEND.
REQ-016 IDLE->LOAD when cs=1 is sampled; that same edge SHALL capture the first miso bit.
REQ-017 Load order: data bit 127 first down to bit 0, then key bit KB-1 first down to bit 0; total 128+KB bits.
REQ-018 A 9-bit counter SHALL count received bits; on the edge capturing bit 128+KB-1, LOAD->WAIT and core_start SHALL be high in the following cycle only.
REQ-019 In WAIT, core_done SHALL latch core_result into a 128-bit output shift register; state goes to HOLD.
REQ-020 HOLD->SEND on the first edge where cs=0 is sampled; WAIT with core_done and cs=0 in the same cycle SHALL go directly to SEND.
REQ-021 In SEND, mosi SHALL present result bit 127 in the first SEND cycle and shift one bit per clock, MSB first, for exactly 128 cycles.
REQ-022 After bit 0 is driven, finished SHALL pulse for one cycle, mosi SHALL return to 0, and state SHALL return to IDLE.
REQ-023 cs falling during LOAD SHALL abort: discard received bits, reset the counter, and return to IDLE with no core_start.
REQ-024 cs rising during WAIT/HOLD/SEND SHALL be ignored; no new load starts until IDLE.
REQ-025 core_done outside WAIT SHALL be ignored.
REQ-026 Extra miso bits after the final bit SHALL be ignored.

Reset
REQ-027 rst low SHALL immediately force IDLE, counter 0, mosi 0, finished 0, core_start 0, busy 0, shift registers 0, and err 0.
REQ-028 Reset mid-operation SHALL discard all partial data, with no finished pulse; the next cs high starts a fresh load.

Configuration
REQ-029 Macro AES_SLV_ERR_EN defined: err port exists and sets on an abort under REQ-023 or on cs rising in WAIT/HOLD/SEND; it clears only on reset.
REQ-030 Macro undefined: no err port or logic; all other behaviour is identical.

Structure
REQ-031 Package aes_slv_pkg SHALL hold the state enum typedef, BLOCK_BITS=128, and the function computing KB from NK.
REQ-032 One sub-module aes_slv_shreg (parameterised width, serial-in/parallel-out and parallel-load/serial-out) SHALL implement both shift registers.

Verification
REQ-033 NK=4, data 00112233445566778899aabbccddeeff, key 000102030405060708090a0b0c0d0e0f shifted in, core model returns 69c4e0d86a7b0430d8cdb78070b4c55a -> core_data/core_key match, one core_start, mosi streams 69c4...c55a MSB first, finished pulses once, 128 cycles after SEND entry.
REQ-034 cs drops after 100 bits -> no core_start, return to IDLE, err=1 (macro on); a following full load then works.
REQ-035 core_done arrives while cs is still high, cs drops 20 cycles later -> SEND begins on the edge where cs=0 is sampled.
REQ-036 rst asserted mid-SEND at bit 60 -> all outputs 0 immediately, no finished; a following full transaction passes.
REQ-037 NK=8, 384-bit load -> core_start follows the 384th bit by one cycle; core_key matches the 256-bit key.

Source files
------------

// File: rtl/aes_slv_pkg.sv
// Shared types and constants for the AES serial slave.
package aes_slv_pkg;

  localparam int unsigned BLOCK_BITS = 128;
  localparam int unsigned CNT_BITS   = 9;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    WAIT,
    HOLD,
    SEND
  } slv_state_e;

  // Key width in bits for a key of nk 32-bit words.
  function automatic int unsigned key_bits(input int unsigned nk);
    return 32 * nk;
  endfunction

endpackage

// File: rtl/aes_slv_shreg.sv
// Shift register: serial-in/parallel-out or parallel-load/serial-out, MSB first.
module aes_slv_shreg #(
  parameter int unsigned WIDTH = 128
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clr,
  input  logic             i_load,
  input  logic             i_shift,
  input  logic             i_sin,
  input  logic [WIDTH-1:0] i_pdata,
  output logic [WIDTH-1:0] o_pdata,
  output logic             o_sout
);

  logic [WIDTH-1:0] r_q;

  // Clear has priority over load, load over shift.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= '0;
    end else if (i_clr) begin
      r_q <= '0;
    end else if (i_load) begin
      r_q <= i_pdata;
    end else if (i_shift) begin
      r_q <= {r_q[WIDTH-2:0], i_sin};
    end
  end

  assign o_pdata = r_q;
  assign o_sout  = r_q[WIDTH-1];

endmodule

// File: rtl/aes_serial_slave.sv
// Serial front end for an AES core: shifts in block+key, runs the core,
// streams the 128-bit result back MSB first.
// Optional sticky protocol-error flag `err` when AES_SLV_ERR_EN is defined.
module aes_serial_slave
  import aes_slv_pkg::*;
#(
  parameter  int unsigned NK = 4,
  localparam int unsigned KB = key_bits(NK)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cs,
  input  logic                  miso,
  output logic                  mosi,
  output logic                  finished,
  output logic                  core_start,
  output logic [BLOCK_BITS-1:0] core_data,
  output logic [KB-1:0]         core_key,
  input  logic                  core_done,
  input  logic [BLOCK_BITS-1:0] core_result,
  output logic                  busy
`ifdef AES_SLV_ERR_EN
  ,
  output logic                  err
`endif
);

  localparam int unsigned         TOTAL    = BLOCK_BITS + KB;
  localparam int unsigned         OUT_W    = BLOCK_BITS + 1;
  localparam logic [CNT_BITS-1:0] LAST_IN  = CNT_BITS'(TOTAL - 1);
  localparam logic [CNT_BITS-1:0] LAST_OUT = CNT_BITS'(BLOCK_BITS - 1);

  slv_state_e          r_state;
  logic [CNT_BITS-1:0] r_cnt;
  logic                r_core_start;
  logic                r_finished;

  logic                w_in_shift;
  logic                w_in_clr;
  logic [TOTAL-1:0]    w_in_pdata;
  logic                w_in_sout;
  logic                w_out_load;
  logic                w_out_shift;
  logic [OUT_W-1:0]    w_out_pin;
  logic [OUT_W-1:0]    w_out_pdata;
  logic                w_out_sout;
  logic                w_unused;

`ifdef AES_SLV_ERR_EN
  logic r_err;
  logic r_cs_q;
  logic w_cs_rise_busy;

  assign w_cs_rise_busy = cs && !r_cs_q &&
                          (r_state == WAIT || r_state == HOLD || r_state == SEND);
  assign err = r_err;
`endif

  // Shift-register control derived from the current state and inputs.
  // The output register is one bit wider than the block: its top bit is the
  // mosi flop. Loading {0,result} keeps mosi low while holding; loading
  // {result,0} places bit 127 on mosi at once for the direct WAIT->SEND path.
  always_comb begin
    w_in_shift  = cs && (r_state == IDLE || r_state == LOAD);
    w_in_clr    = !cs && (r_state == LOAD);
    w_out_load  = (r_state == WAIT) && core_done;
    w_out_pin   = cs ? {1'b0, core_result} : {core_result, 1'b0};
    w_out_shift = ((r_state == HOLD) && !cs) || (r_state == SEND);
  end

  aes_slv_shreg #(.WIDTH(TOTAL)) u_in_shreg (
    .clk     (clk),
    .rst_n   (rst),
    .i_clr   (w_in_clr),
    .i_load  (1'b0),
    .i_shift (w_in_shift),
    .i_sin   (miso),
    .i_pdata ('0),
    .o_pdata (w_in_pdata),
    .o_sout  (w_in_sout)
  );

  aes_slv_shreg #(.WIDTH(OUT_W)) u_out_shreg (
    .clk     (clk),
    .rst_n   (rst),
    .i_clr   (1'b0),
    .i_load  (w_out_load),
    .i_shift (w_out_shift),
    .i_sin   (1'b0),
    .i_pdata (w_out_pin),
    .o_pdata (w_out_pdata),
    .o_sout  (w_out_sout)
  );

  assign w_unused = ^{w_in_sout, w_out_pdata};

  // Protocol FSM with bit counter and registered strobes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_core_start <= 1'b0;
      r_finished   <= 1'b0;
`ifdef AES_SLV_ERR_EN
      r_err        <= 1'b0;
      r_cs_q       <= 1'b0;
`endif
    end else begin
      r_core_start <= 1'b0;
      r_finished   <= 1'b0;
`ifdef AES_SLV_ERR_EN
      r_cs_q       <= cs;
      if (w_cs_rise_busy) begin
        r_err <= 1'b1;
      end
`endif
      case (r_state)
        IDLE: begin
          if (cs) begin
            r_state <= LOAD;
            r_cnt   <= CNT_BITS'(1);
          end
        end
        LOAD: begin
          if (!cs) begin
            r_state <= IDLE;
            r_cnt   <= '0;
`ifdef AES_SLV_ERR_EN
            r_err   <= 1'b1;
`endif
          end else if (r_cnt == LAST_IN) begin
            r_state      <= WAIT;
            r_cnt        <= '0;
            r_core_start <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        WAIT: begin
          if (core_done) begin
            r_state <= cs ? HOLD : SEND;
            r_cnt   <= '0;
          end
        end
        HOLD: begin
          if (!cs) begin
            r_state <= SEND;
          end
        end
        SEND: begin
          if (r_cnt == LAST_OUT) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_finished <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign mosi       = w_out_sout;
  assign finished   = r_finished;
  assign core_start = r_core_start;
  assign core_data  = w_in_pdata[TOTAL-1 -: BLOCK_BITS];
  assign core_key   = w_in_pdata[KB-1:0];
  assign busy       = (r_state != IDLE);

endmodule

// File: tb/tb_aes_serial_slave.sv
// Bench for aes_serial_slave: one NK=4 and one NK=8 instance, each driven
// with randomized transactions and checked against a rule-level model.
module tb_aes_serial_slave;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]   rst, cs, miso, core_done;
  logic [127:0] cres [2];

  logic         mosi4, fin4, start4, busy4;
  logic         mosi8, fin8, start8, busy8;
  logic [127:0] cdata4, cdata8;
  logic [127:0] ckey4;
  logic [255:0] ckey8;
`ifdef AES_SLV_ERR_EN
  logic         err4, err8;
`endif

  int starts [2];
  int fins   [2];
  int errors = 0;
  int checks = 0;

  aes_serial_slave #(.NK(4)) u_dut4 (
    .clk(clk), .rst(rst[0]), .cs(cs[0]), .miso(miso[0]), .mosi(mosi4),
    .finished(fin4), .core_start(start4), .core_data(cdata4), .core_key(ckey4),
    .core_done(core_done[0]), .core_result(cres[0]), .busy(busy4)
`ifdef AES_SLV_ERR_EN
    , .err(err4)
`endif
  );

  aes_serial_slave #(.NK(8)) u_dut8 (
    .clk(clk), .rst(rst[1]), .cs(cs[1]), .miso(miso[1]), .mosi(mosi8),
    .finished(fin8), .core_start(start8), .core_data(cdata8), .core_key(ckey8),
    .core_done(core_done[1]), .core_result(cres[1]), .busy(busy8)
`ifdef AES_SLV_ERR_EN
    , .err(err8)
`endif
  );

  // Count strobe cycles per instance.
  always @(posedge clk) begin
    if (start4) starts[0] <= starts[0] + 1;
    if (start8) starts[1] <= starts[1] + 1;
    if (fin4)   fins[0]   <= fins[0] + 1;
    if (fin8)   fins[1]   <= fins[1] + 1;
  end

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic get_mosi(input int s);  return (s == 0) ? mosi4  : mosi8;  endfunction
  function automatic logic get_fin(input int s);   return (s == 0) ? fin4   : fin8;   endfunction
  function automatic logic get_start(input int s); return (s == 0) ? start4 : start8; endfunction
  function automatic logic get_busy(input int s);  return (s == 0) ? busy4  : busy8;  endfunction
  function automatic logic [127:0] get_data(input int s); return (s == 0) ? cdata4 : cdata8; endfunction
  function automatic logic [255:0] get_key(input int s);
    return (s == 0) ? {128'b0, ckey4} : ckey8;
  endfunction
`ifdef AES_SLV_ERR_EN
  function automatic logic get_err(input int s); return (s == 0) ? err4 : err8; endfunction
`endif

  // Expected key as seen on core_key for a kb-bit key.
  function automatic logic [255:0] kmask(input logic [255:0] k, input int kb);
    return (kb == 128) ? {128'b0, k[127:0]} : k;
  endfunction

  // j-th bit of the load stream: data MSB first, then key MSB first.
  function automatic logic sbit(input int kb, input logic [127:0] d, input logic [255:0] k, input int j);
    if (j < 128) return d[127 - j];
    return k[kb - 1 - (j - 128)];
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [255:0] rnd256();
    return {rnd128(), rnd128()};
  endfunction

  // Full transaction. dly: cycles after core_start-cycle until core_done;
  // csd: cycles after core_start-cycle that cs stays high; rst_bit >= 0 resets
  // the instance while that result bit is on mosi.
  task automatic run_txn(input int s, input logic [127:0] d, input logic [255:0] k,
                         input logic [127:0] r, input int dly, input int csd, input int rst_bit);
    int kb, n, ts, st0, fn0;
    kb  = (s == 0) ? 128 : 256;
    n   = 128 + kb;
    st0 = starts[s];
    fn0 = fins[s];
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (i == n - 1) check("start_before_last", get_start(s), 1'b0);
      cs[s]   = 1'b1;
      miso[s] = sbit(kb, d, k, i);
    end
    @(negedge clk);
    check("core_start", get_start(s), 1'b1);
    check("busy_wait", get_busy(s), 1'b1);
    check("core_data", get_data(s), d);
    check("core_key", get_key(s), kmask(k, kb));
    ts = (dly > csd) ? dly : csd;
    for (int c = 0; c <= ts; c++) begin
      if (c > 0) @(negedge clk);
      if (c == dly) check("data_stable", get_data(s), d);
      core_done[s] = (c == dly);
      cres[s]      = (c == dly) ? r : rnd128();
      cs[s]        = (c < csd);
      miso[s]      = 1'($urandom);
    end
    @(negedge clk);
    core_done[s] = 1'b0;
    cres[s]      = rnd128();
    cs[s]        = 1'b0;
    miso[s]      = 1'b0;
    for (int b = 0; b < 128; b++) begin
      if (b > 0) @(negedge clk);
      check("mosi", get_mosi(s), r[127 - b]);
      if (b == rst_bit) begin
        rst[s] = 1'b0;
        #1;
        check("rst_mosi", get_mosi(s), 1'b0);
        check("rst_busy", get_busy(s), 1'b0);
        check("rst_fin", get_fin(s), 1'b0);
        check("rst_start", get_start(s), 1'b0);
        check("rst_data", get_data(s), 128'b0);
        check("rst_key", get_key(s), 256'b0);
`ifdef AES_SLV_ERR_EN
        check("rst_err", get_err(s), 1'b0);
`endif
        @(negedge clk);
        rst[s] = 1'b1;
        repeat (3) @(negedge clk);
        check("no_fin_after_rst", fins[s], fn0);
        check("one_start_rst", starts[s], st0 + 1);
        return;
      end
    end
    @(negedge clk);
    check("mosi_idle", get_mosi(s), 1'b0);
    check("finished", get_fin(s), 1'b1);
    check("busy_idle", get_busy(s), 1'b0);
    @(negedge clk);
    check("finished_pulse", get_fin(s), 1'b0);
    check("one_start", starts[s], st0 + 1);
    check("one_finish", fins[s], fn0 + 1);
  endtask

  // Load nb bits then drop cs: the load must be abandoned.
  task automatic abort_txn(input int s, input int nb);
    int st0;
    st0 = starts[s];
    for (int i = 0; i < nb; i++) begin
      @(negedge clk);
      cs[s]   = 1'b1;
      miso[s] = 1'($urandom);
    end
    @(negedge clk);
    cs[s]   = 1'b0;
    miso[s] = 1'b0;
    @(negedge clk);
    check("abort_busy", get_busy(s), 1'b0);
`ifdef AES_SLV_ERR_EN
    check("abort_err", get_err(s), 1'b1);
`endif
    repeat (3) @(negedge clk);
    check("abort_no_start", starts[s], st0);
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int s;
    rst       = '0;
    cs        = '0;
    miso      = '0;
    core_done = '0;
    cres[0]   = '0;
    cres[1]   = '0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check("reset_mosi", get_mosi(i), 1'b0);
      check("reset_busy", get_busy(i), 1'b0);
      check("reset_start", get_start(i), 1'b0);
      check("reset_fin", get_fin(i), 1'b0);
      check("reset_data", get_data(i), 128'b0);
      check("reset_key", get_key(i), 256'b0);
`ifdef AES_SLV_ERR_EN
      check("reset_err", get_err(i), 1'b0);
`endif
    end
    rst = '1;
    @(negedge clk);

    // Known-answer vector, direct WAIT->SEND.
    run_txn(0, 128'h00112233445566778899aabbccddeeff,
            {128'b0, 128'h000102030405060708090a0b0c0d0e0f},
            128'h69c4e0d86a7b0430d8cdb78070b4c55a, 3, 3, -1);
`ifdef AES_SLV_ERR_EN
    check("err_clean", get_err(0), 1'b0);
`endif
    abort_txn(0, 100);
    run_txn(0, rnd128(), rnd256(), rnd128(), 1, 4, -1);
    // core_done while cs still high, cs drops much later.
    run_txn(0, rnd128(), rnd256(), rnd128(), 2, 22, -1);
    // Reset while result bit 60 is on mosi.
    run_txn(0, rnd128(), rnd256(), rnd128(), 1, 0, 60);
    run_txn(0, rnd128(), rnd256(), rnd128(), 5, 2, -1);
`ifdef AES_SLV_ERR_EN
    check("err_after_rst", get_err(0), 1'b0);
`endif
    // 256-bit key instance.
    run_txn(1, rnd128(), rnd256(), rnd128(), 0, 0, -1);
    run_txn(1, rnd128(), rnd256(), rnd128(), 4, 1, -1);
    repeat (6) begin
      s = int'($urandom_range(0, 1));
      run_txn(s, rnd128(), rnd256(), rnd128(),
              int'($urandom_range(0, 5)), int'($urandom_range(0, 5)), -1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
